// File: rtl/hilo_pkg.sv
// hilo_pkg: op codes, FSM states and HI/LO write-data select helpers shared by the HI/LO sequencer.
package hilo_pkg;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  typedef enum logic [1:0] {IDLE, MULT_WAIT, DIV_WAIT, WRITE} state_t;
  localparam int SEL_DIV  = 0;
  localparam int SEL_MULT = 1;
  localparam int SEL_RS   = 2;
  function automatic logic [2:0] hi_sel_of(input logic [2:0] op);
    return op <= OP_MULTU ? 3'b001 << SEL_MULT
         : op <= OP_DIVU  ? 3'b001 << SEL_DIV
         : op == OP_MTHI  ? 3'b001 << SEL_RS : 3'b000;
  endfunction
  function automatic logic [2:0] lo_sel_of(input logic [2:0] op);
    return op <= OP_MULTU ? 3'b001 << SEL_MULT
         : op <= OP_DIVU  ? 3'b001 << SEL_DIV
         : op == OP_MTLO  ? 3'b001 << SEL_RS : 3'b000;
  endfunction
endpackage

// File: rtl/hilo_timeout_cnt.sv
// hilo_timeout_cnt: counts WAIT cycles; flags the start cycle and the last cycle before abort.
module hilo_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic first,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign first = cnt == '0;
  assign expired = cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences MULT/DIV/MTHI/MTLO requests, launches the mult/div units and drives
// the registered one-hot HI/LO write-data selects and write enables.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  input  logic [2:0] op_code,
  output logic       op_ready,
  output logic       busy,
  output logic       mult_start,
  output logic       div_start,
  output logic       md_signed,
  input  logic       mult_done,
  input  logic       div_done,
  output logic       MUX_HI_WDATA_DIV,
  output logic       MUX_HI_WDATA_MULT,
  output logic       MUX_HI_WDATA_RS,
  output logic       MUX_LO_WDATA_DIV,
  output logic       MUX_LO_WDATA_MULT,
  output logic       MUX_LO_WDATA_RS,
  output logic       hi_we,
  output logic       lo_we,
  output logic       op_done,
  output logic       op_err
);
  state_t state, state_n;
  logic [2:0] op_q, op_n, hi_sel, lo_sel, hi_sel_n, lo_sel_n;
  logic accept, illegal, wait_st, done_m, first, expired, wr;
  logic md_signed_n, mult_start_n, div_start_n, op_err_n;
  hilo_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst_n(rst_n), .clear(!wait_st), .enable(wait_st),
    .first(first), .expired(expired)
  );
  always_comb begin
    accept = state == IDLE && op_valid;
    illegal = op_code > OP_MTLO;
    wait_st = state == MULT_WAIT || state == DIV_WAIT;
    done_m = state == MULT_WAIT ? mult_done : div_done;
    op_n = accept ? op_code : op_q;
    // done is not trusted in the launch cycle; a late done wins over the timeout
    state_n = state == WRITE ? IDLE
            : wait_st ? (done_m && !first ? WRITE : expired ? IDLE : state)
            : !op_valid || illegal ? IDLE
            : op_code <= OP_MULTU ? MULT_WAIT
            : op_code <= OP_DIVU ? DIV_WAIT : WRITE;
    wr = state_n == WRITE;
    md_signed_n = accept && !illegal ? (op_code == OP_MULT || op_code == OP_DIV) : md_signed;
    mult_start_n = state == IDLE && state_n == MULT_WAIT;
    div_start_n = state == IDLE && state_n == DIV_WAIT;
    op_err_n = (accept && illegal) || (wait_st && state_n == IDLE);
    hi_sel_n = wr ? hi_sel_of(op_n) : 3'b000;
    lo_sel_n = wr ? lo_sel_of(op_n) : 3'b000;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op_q <= OP_MULT;
      md_signed <= 1'b0;
      mult_start <= 1'b0;
      div_start <= 1'b0;
      hi_sel <= '0;
      lo_sel <= '0;
      hi_we <= 1'b0;
      lo_we <= 1'b0;
      op_done <= 1'b0;
      op_err <= 1'b0;
    end else begin
      state <= state_n;
      op_q <= op_n;
      md_signed <= md_signed_n;
      mult_start <= mult_start_n;
      div_start <= div_start_n;
      hi_sel <= hi_sel_n;
      lo_sel <= lo_sel_n;
      hi_we <= |hi_sel_n;
      lo_we <= |lo_sel_n;
      op_done <= wr;
      op_err <= op_err_n;
    end
  assign op_ready = state == IDLE;
  assign busy = !op_ready;
  assign MUX_HI_WDATA_DIV = hi_sel[SEL_DIV];
  assign MUX_HI_WDATA_MULT = hi_sel[SEL_MULT];
  assign MUX_HI_WDATA_RS = hi_sel[SEL_RS];
  assign MUX_LO_WDATA_DIV = lo_sel[SEL_DIV];
  assign MUX_LO_WDATA_MULT = lo_sel[SEL_MULT];
  assign MUX_LO_WDATA_RS = lo_sel[SEL_RS];
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: plans a per-cycle timeline of inputs and expected outputs from transaction
// rules (accept cycle, launch, honoured done, write or timeout) and compares every cycle.
module tb_hilo_ctrl;
  localparam int T = 8;
  localparam int NC = 2500;
  localparam int N = NC + 64;
  localparam int B_RDY = 13, B_BUSY = 12, B_MS = 11, B_DS = 10, B_HD = 9, B_HM = 8, B_HR = 7;
  localparam int B_LD = 6, B_LM = 5, B_LR = 4, B_HW = 3, B_LW = 2, B_DN = 1, B_ER = 0;
  localparam logic [13:0] IDLE_V = 14'b1 << B_RDY;
  logic clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0, mult_done = 1'b0, div_done = 1'b0;
  logic [2:0] op_code = 3'd0;
  logic op_ready, busy, mult_start, div_start, md_signed;
  logic hi_div, hi_mult, hi_rs, lo_div, lo_mult, lo_rs, hi_we, lo_we, op_done, op_err;
  logic [13:0] obs;
  logic [13:0] exp_v[N], obs_v[N];
  logic md_care[N], md_exp[N], obs_md[N], drv_v[N], drv_md[N], drv_dd[N];
  logic [2:0] drv_code[N];
  int c, n_chk, n_fail;

  hilo_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .busy(busy), .mult_start(mult_start), .div_start(div_start),
    .md_signed(md_signed), .mult_done(mult_done), .div_done(div_done),
    .MUX_HI_WDATA_DIV(hi_div), .MUX_HI_WDATA_MULT(hi_mult), .MUX_HI_WDATA_RS(hi_rs),
    .MUX_LO_WDATA_DIV(lo_div), .MUX_LO_WDATA_MULT(lo_mult), .MUX_LO_WDATA_RS(lo_rs),
    .hi_we(hi_we), .lo_we(lo_we), .op_done(op_done), .op_err(op_err)
  );

  always #5 clk = ~clk;
  assign obs = {op_ready, busy, mult_start, div_start, hi_div, hi_mult, hi_rs,
                lo_div, lo_mult, lo_rs, hi_we, lo_we, op_done, op_err};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Busy cycles carry random (or forced MTHI) requests that must be ignored.
  task automatic mark_busy(input int x, input bit f4);
    exp_v[x][B_RDY] = 1'b0;
    exp_v[x][B_BUSY] = 1'b1;
    drv_v[x] = f4 ? 1'b1 : 1'($urandom_range(0, 1));
    drv_code[x] = f4 ? 3'd4 : 3'($urandom_range(0, 7));
  endtask

  // mode 0: matching done held high from wait index d; mode 1: single pulse at wait index d.
  task automatic plan(input int code, input int mode, input int d, input bit f4);
    int w0, kk, x;
    bit ok, is_m, sgn;
    drv_v[c] = 1'b1;
    drv_code[c] = 3'(code);
    if (code > 5) begin
      exp_v[c + 1][B_ER] = 1'b1;
      c += 1;
      return;
    end
    if (code > 3) begin
      mark_busy(c + 1, f4);
      exp_v[c + 1][B_DN] = 1'b1;
      exp_v[c + 1][code == 4 ? B_HR : B_LR] = 1'b1;
      exp_v[c + 1][code == 4 ? B_HW : B_LW] = 1'b1;
      c += 2;
      return;
    end
    is_m = code < 2;
    sgn = code == 0 || code == 2;
    w0 = c + 1;
    exp_v[w0][is_m ? B_MS : B_DS] = 1'b1;
    kk = mode == 0 ? (d < 1 ? 1 : d) : d;
    ok = kk >= 1 && kk <= T - 1;
    for (int i = 0; i <= (ok ? kk : T - 1); i++) begin
      mark_busy(w0 + i, f4);
      md_care[w0 + i] = 1'b1;
      md_exp[w0 + i] = sgn;
      if (is_m) drv_md[w0 + i] = mode == 0 ? (i >= d) : (i == d);
      else drv_dd[w0 + i] = mode == 0 ? (i >= d) : (i == d);
    end
    if (ok) begin
      x = w0 + kk + 1;
      mark_busy(x, f4);
      md_care[x] = 1'b1;
      md_exp[x] = sgn;
      exp_v[x][is_m ? B_HM : B_HD] = 1'b1;
      exp_v[x][is_m ? B_LM : B_LD] = 1'b1;
      exp_v[x][B_HW] = 1'b1;
      exp_v[x][B_LW] = 1'b1;
      exp_v[x][B_DN] = 1'b1;
      c = x + 1;
    end else begin
      exp_v[w0 + T][B_ER] = 1'b1;
      c = w0 + T;
    end
  endtask

  initial begin
    int we_cnt;
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < N; i++) begin
      exp_v[i] = IDLE_V;
      md_care[i] = 1'b0;
      md_exp[i] = 1'b0;
      drv_v[i] = 1'b0;
      drv_code[i] = 3'd0;
      drv_md[i] = 1'($urandom_range(0, 1));
      drv_dd[i] = 1'($urandom_range(0, 1));
    end
    c = 0;
    plan(0, 0, 3, 1'b0);
    plan(3, 0, 0, 1'b0);
    plan(4, 0, 0, 1'b0);
    plan(5, 0, 0, 1'b0);
    plan(2, 0, 99, 1'b0);
    plan(6, 0, 0, 1'b0);
    plan(0, 1, 5, 1'b1);
    while (c < NC - 40) begin
      c += $urandom_range(0, 2);
      plan($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, T + 1), 1'b0);
    end
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(obs), 32'(IDLE_V));
    check("reset_md_signed", 32'(md_signed), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < NC; k++) begin
      obs_v[k] = obs;
      obs_md[k] = md_signed;
      check($sformatf("cyc%0d outputs", k), 32'(obs), 32'(exp_v[k]));
      if (md_care[k]) check($sformatf("cyc%0d md_signed", k), 32'(md_signed), 32'(md_exp[k]));
      op_valid = drv_v[k];
      op_code = drv_code[k];
      mult_done = drv_md[k];
      div_done = drv_dd[k];
      @(negedge clk);
    end
    check("pin_mult_start_c1", 32'(obs_v[1][B_MS]), 32'd1);
    check("pin_mult_signed_c2", 32'(obs_md[2]), 32'd1);
    check("pin_mult_done_c5", 32'({obs_v[5][B_HM], obs_v[5][B_LM], obs_v[5][B_DN]}), 32'd7);
    check("pin_divu_start_c7", 32'({obs_v[7][B_DS], obs_md[7]}), 32'd2);
    check("pin_divu_write_c9", 32'({obs_v[9][B_HD], obs_v[9][B_LD], obs_v[9][B_DN]}), 32'd7);
    check("pin_mthi_c11", 32'({obs_v[11][B_HR], obs_v[11][B_HW], obs_v[11][B_LW]}), 32'd6);
    check("pin_mtlo_c13", 32'({obs_v[13][B_LR], obs_v[13][B_LW], obs_v[13][B_HW]}), 32'd6);
    check("pin_timeout_err_c23", 32'({obs_v[22][B_ER], obs_v[23][B_ER], obs_v[23][B_RDY]}), 32'd3);
    check("pin_illegal_err_c24", 32'({obs_v[24][B_ER], obs_v[24][B_RDY]}), 32'd3);
    we_cnt = 0;
    for (int k = 14; k <= 24; k++) we_cnt += int'(obs_v[k][B_HW]) + int'(obs_v[k][B_LW]);
    check("pin_no_write_on_timeout", 32'(we_cnt), 32'd0);
    mult_done = 1'b0;
    div_done = 1'b0;
    op_valid = 1'b1;
    op_code = 3'd0;
    @(negedge clk);
    check("rst_seq_mult_start", 32'({mult_start, busy}), 32'd3);
    op_valid = 1'b0;
    @(negedge clk);
    check("rst_seq_second_wait", 32'({mult_start, busy}), 32'd1);
    #2 rst_n = 1'b0;
    mult_done = 1'b1;
    #1 check("rst_seq_async_drop", 32'(obs), 32'(IDLE_V));
    check("rst_seq_md_signed", 32'(md_signed), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_reset%0d", k), 32'(obs), 32'(IDLE_V));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
